// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register, boot hold,
// load-use stall and EX-stage redirect with misaligned-target flagging.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BOOT_WAIT = 1,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hz_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        pc_misaligned
);

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  boot_cnt_q, boot_cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic        id_valid_q, id_valid_d;
    logic        pc_misaligned_q, pc_misaligned_d;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        state_d         = state_q;
        boot_cnt_d      = boot_cnt_q;
        pc_d            = pc_q;
        id_pc_d         = id_pc_q;
        id_pc_plus4_d   = id_pc_plus4_q;
        id_instr_d      = id_instr_q;
        id_valid_d      = id_valid_q;
        pc_misaligned_d = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // Boot always spends at least one edge so instruction_mem can load.
                id_instr_d = NOP_INSTR;
                id_valid_d = 1'b0;
                boot_cnt_d = (boot_cnt_q == 4'd0) ? 4'd0 : boot_cnt_q - 4'd1;
                if (boot_cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (ex_redirect) begin
                    // Redirect beats stall: the stalled instruction is wrong-path.
                    pc_d            = {ex_target[31:2], 2'b00};
                    id_instr_d      = NOP_INSTR;
                    id_valid_d      = 1'b0;
                    pc_misaligned_d = |ex_target[1:0];
                end else if (!hz_stall) begin
                    pc_d          = pc_plus4;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_plus4;
                    id_instr_d    = imem_instr;
                    id_valid_d    = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_BOOT;
            boot_cnt_q      <= BOOT_INIT;
            pc_q            <= RESET_PC;
            id_pc_q         <= 32'h0;
            id_pc_plus4_q   <= 32'h0;
            id_instr_q      <= NOP_INSTR;
            id_valid_q      <= 1'b0;
            pc_misaligned_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            boot_cnt_q      <= boot_cnt_d;
            pc_q            <= pc_d;
            id_pc_q         <= id_pc_d;
            id_pc_plus4_q   <= id_pc_plus4_d;
            id_instr_q      <= id_instr_d;
            id_valid_q      <= id_valid_d;
            pc_misaligned_q <= pc_misaligned_d;
        end
    end

    assign pc            = pc_q;
    assign id_pc         = id_pc_q;
    assign id_pc_plus4   = id_pc_plus4_q;
    assign id_instr      = id_instr_q;
    assign id_valid      = id_valid_q;
    assign pc_misaligned = pc_misaligned_q;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the hazard-aware RISC-V pipeline. Holds the program counter, drives the byte address into `instruction_mem`, captures the returned instruction into the IF/ID pipeline register, and applies stall and redirect/flush requests from hazard detection and EX-stage branch resolution. It sits directly upstream of `instruction_mem` and directly upstream of decode.

## Interface

- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `BOOT_WAIT`, 1, cycles after reset release during which PC holds and no valid instruction is issued. This covers `instruction_mem` loading its contents on its first post-reset edge. Range 0–15.
- `NOP_INSTR`, 32'h0000_0000, bubble encoding written to `id_instr` on reset and flush.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `hz_stall` in 1: load-use stall from hazard detection; freezes PC and IF/ID.
- `ex_redirect` in 1: taken branch or jump resolved in EX.
- `ex_target` in 32: redirect byte address.
- `imem_instr` in 32: `instruction_out` from `instruction_mem`; combinational for the current `pc`.
- `pc` out 32: current fetch address; drives `instruction_mem.PC_in`.
- `id_pc` out 32: PC of the instruction held in IF/ID.
- `id_pc_plus4` out 32: `id_pc + 4`.
- `id_instr` out 32: instruction held in IF/ID.
- `id_valid` out 1: IF/ID holds a real (non-bubble) instruction.
- `pc_misaligned` out 1: one-cycle pulse when a redirect target has `[1:0] != 0`.

## Operation

- Reset values, applied at any edge with `rst_n=0`, including mid-operation:
  - `pc=RESET_PC`
  - `id_pc=0`, `id_pc_plus4=0`
  - `id_instr=NOP_INSTR`, `id_valid=0`
  - `pc_misaligned=0`
  - boot counter `=BOOT_WAIT`
- State machine:
  - BOOT: entered on reset. Counter decrements each cycle. PC holds. IF/ID loads a bubble. Inputs `hz_stall` and `ex_redirect` are ignored.
  - BOOT → RUN when the counter reaches 0. With `BOOT_WAIT=0`, RUN is entered on the first edge after reset release.
- RUN, per edge, in priority order:
  1. `ex_redirect=1`: `pc <= {ex_target[31:2],2'b00}`. IF/ID loads a bubble (`id_instr=NOP_INSTR`, `id_valid=0`, `id_pc` and `id_pc_plus4` unchanged). `pc_misaligned <= |ex_target[1:0]`. Redirect overrides `hz_stall` in the same cycle, because the stalled instruction is wrong-path.
  2. `hz_stall=1`: `pc` and all IF/ID registers hold. `pc_misaligned <= 0`.
  3. Otherwise: `pc <= pc + 4` (modulo 2^32). IF/ID loads `id_pc=pc`, `id_pc_plus4=pc+4`, `id_instr=imem_instr`, `id_valid=1`.
- `pc_misaligned` is cleared on every edge where it is not set by rule 1.
- Arithmetic: all adds are 32-bit unsigned, carry-out discarded. `pc=32'hFFFF_FFFC` advances to `32'h0000_0000`.

## Timing

- IF latency is 1 cycle: the instruction at `pc` in cycle N appears on `id_instr` after edge N+1.
- Redirect:
  - `ex_redirect` high in cycle N gives `pc=target` after edge N+1 and a bubble in IF/ID after edge N+1.
  - The target instruction reaches IF/ID after edge N+2.
  - Redirect penalty is 2 cycles: the bubble at N+1 plus the squashed EX-side instruction, which is handled downstream.
- Stall held for k cycles freezes `pc` and IF/ID for exactly k edges. Fetch resumes on the first edge with `hz_stall=0`.
- Consecutive redirects on back-to-back cycles: each takes effect; the last one wins.
- All outputs are registered. There is no combinational path from inputs to outputs other than `pc` → `instruction_mem` → `imem_instr`, which is external.

## Test plan

- Reset then run, `BOOT_WAIT=1`:
  - Expected `pc` sequence: 0, 0, 4, 8, 12.
  - `id_valid` first rises with `id_pc=0` two edges after reset release.
  - `id_instr` follows the memory image: 0x00000000, 0x403081B3-style sub at 4, and so on.
- Stall: assert `hz_stall` for 2 cycles while `pc=8`.
  - `pc` stays 8 and `id_pc` stays 4 for 2 edges.
  - Next edge gives `pc=12`, `id_pc=8`.
- Redirect with simultaneous stall: `ex_redirect=1`, `ex_target=32'h10`, `hz_stall=1`.
  - Next edge: `pc=0x10`, `id_valid=0`, `id_instr=0`.
  - Following edge: `id_pc=0x10`, `id_valid=1`.
- Misaligned target `0x16`:
  - `pc=0x14`.
  - `pc_misaligned` high for exactly one cycle.
- Wrap: force redirect to `0xFFFFFFFC`, run 2 edges.
  - `pc` goes to 0.
  - `id_pc_plus4=0` when `id_pc=0xFFFFFFFC`.
- Reset mid-run: drop `rst_n` for one edge while `pc=0x14` with `id_valid=1`.
  - All outputs take their reset values.
  - BOOT repeats.
